// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit arbiter.
// Holds the arbiter FSM encoding and the default transmit word width.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;
    localparam int LOCK_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/spi_tx_arbiter_rr_picker.sv
// Combinational round-robin search: the first set request at or above ptr,
// wrapping from the top index back to zero.
module rr_picker #(
    parameter  int P_NUM_REQ = 4,
    localparam int IDX_W     = $clog2(P_NUM_REQ)
) (
    input  logic [P_NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest match is written last.
        for (int i = P_NUM_REQ - 1; i >= 0; i--) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(ptr) + i) % P_NUM_REQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter feeding one SPI transmitter from several requesters,
// with burst locking on req_last and a forced release after an idle timeout.
module spi_tx_arbiter
    import spi_pkg::*;
#(
    parameter  int P_NUM_REQ      = 4,
    parameter  int P_DATA_WIDTH   = SPI_DATA_WIDTH,
    parameter  int P_LOCK_TIMEOUT = 16,
    localparam int IDX_W          = $clog2(P_NUM_REQ)
) (
    input  logic                                  clk_100,
    input  logic                                  a_rst_n,
    input  logic [P_NUM_REQ-1:0]                  req_valid,
    input  logic [P_NUM_REQ-1:0][P_DATA_WIDTH-1:0] req_data,
    input  logic [P_NUM_REQ-1:0]                  req_last,
    output logic [P_NUM_REQ-1:0]                  req_ready,
    output logic                                  tx_valid,
    output logic [P_DATA_WIDTH-1:0]               tx_data,
    input  logic                                  tx_ready,
    output logic [IDX_W-1:0]                      grant_id,
    output logic                                  busy,
    output logic                                  timeout_evt
);

    arb_state_t                state;
    logic [IDX_W-1:0]          rr_ptr;
    logic [LOCK_CNT_WIDTH-1:0] idle_cnt;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             owner_valid;
    logic             owner_last;
    logic             handshake;
    logic [IDX_W-1:0] next_ptr;

    rr_picker #(
        .P_NUM_REQ(P_NUM_REQ)
    ) u_rr_picker (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .found(pick_found),
        .idx  (pick_idx)
    );

    assign owner_valid = req_valid[grant_id];
    assign owner_last  = req_last[grant_id];
    assign handshake   = (state == GRANT) && owner_valid && tx_ready;
    assign next_ptr    = (grant_id == IDX_W'(P_NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

    always_comb begin
        req_ready = '0;
        tx_valid  = 1'b0;
        tx_data   = req_data[grant_id];
        if (state == GRANT) begin
            tx_valid            = owner_valid;
            req_ready[grant_id] = tx_ready;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            idle_cnt    <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        idle_cnt <= '0;
                        if (owner_last) begin
                            rr_ptr <= next_ptr;
                            state  <= RELEASE;
                        end
                    end else if (owner_valid) begin
                        idle_cnt <= '0;
                    // The edge that would bring the count to the limit fires the release.
                    end else if (idle_cnt == LOCK_CNT_WIDTH'(P_LOCK_TIMEOUT - 1)) begin
                        idle_cnt    <= '0;
                        timeout_evt <= 1'b1;
                        rr_ptr      <= next_ptr;
                        state       <= RELEASE;
                    end else begin
                        idle_cnt <= idle_cnt + LOCK_CNT_WIDTH'(1);
                    end
                end
                RELEASE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_spi_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic                 clk_100 = 1'b0;
    logic                 a_rst_n = 1'b0;
    logic [N-1:0]         req_valid;
    logic [N-1:0][W-1:0]  req_data;
    logic [N-1:0]         req_last;
    logic [N-1:0]         req_ready;
    logic                 tx_valid;
    logic [W-1:0]         tx_data;
    logic                 tx_ready;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_evt;

    spi_tx_arbiter #(
        .P_NUM_REQ     (N),
        .P_DATA_WIDTH  (W),
        .P_LOCK_TIMEOUT(T)
    ) dut (
        .clk_100    (clk_100),
        .a_rst_n    (a_rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_evt(timeout_evt)
    );

    always #5 clk_100 = ~clk_100;

    int checks = 0;
    int errors = 0;

    // Per-requester pending words: {last, data}
    logic [8:0] q [N][$];
    bit         stall [N];

    // Reference model: owner (-1 = none), release flag, pointer, idle count
    int m_owner;
    int m_ptr;
    int m_idle;
    bit m_rel;
    bit m_tevt;

    int         log_owner [$];
    logic [7:0] log_data  [$];

    bit         s_busy, s_txv, s_tevt;
    int         s_gid;
    logic [7:0] s_data;
    logic [N-1:0] s_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i] = !stall[i];
                req_data[i]  = q[i][0][7:0];
                req_last[i]  = q[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = '0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_idle  = 0;
        m_rel   = 1'b0;
        m_tevt  = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance the model,
    // then update requester queues just after the rising edge.
    task automatic cycle();
        bit           pop;
        int           hs_owner;
        bit           exp_txv;
        logic [N-1:0] exp_rdy;
        pop      = 1'b0;
        hs_owner = 0;
        @(negedge clk_100);
        s_busy = busy;
        s_txv  = tx_valid;
        s_tevt = timeout_evt;
        s_gid  = int'(grant_id);
        s_data = tx_data;
        s_rdy  = req_ready;

        exp_txv = (m_owner >= 0) && req_valid[m_owner];
        exp_rdy = '0;
        if (m_owner >= 0 && tx_ready) exp_rdy[m_owner] = 1'b1;
        check("busy", 32'(busy), 32'((m_owner >= 0) || m_rel));
        check("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
        check("tx_valid", 32'(tx_valid), 32'(exp_txv));
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_owner >= 0) check("grant_id", 32'(grant_id), 32'(m_owner));
        if (exp_txv) check("tx_data", 32'(tx_data), 32'(q[m_owner][0][7:0]));

        if (m_rel) begin
            m_rel  = 1'b0;
            m_tevt = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && req_valid[c]) begin
                    m_owner = c;
                    m_idle  = 0;
                end
            end
        end else if (req_valid[m_owner] && tx_ready) begin
            pop      = 1'b1;
            hs_owner = m_owner;
            log_owner.push_back(m_owner);
            log_data.push_back(q[m_owner][0][7:0]);
            m_idle = 0;
            if (req_last[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_rel   = 1'b1;
            end
        end else if (req_valid[m_owner]) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == T) begin
                m_tevt  = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_rel   = 1'b1;
            end
        end

        @(posedge clk_100);
        #1;
        if (pop) q[hs_owner].delete(0);
        drive_inputs();
    endtask

    task automatic run_until_log(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (log_owner.size() < target && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(log_owner.size() >= target), 32'd1);
    endtask

    task automatic drain(input string tag);
        int left;
        int n;
        n = 0;
        left = 1;
        while (left != 0 && n < 1000) begin
            cycle();
            n++;
            left = 0;
            for (int i = 0; i < N; i++) left += q[i].size();
        end
        repeat (3) cycle();
        check(tag, 32'(left), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_s3 [4] = '{8'h11, 8'h22, 8'h33, 8'h55};

        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) stall[i] = 1'b0;
        model_reset();
        drive_inputs();

        // Reset values
        repeat (2) @(posedge clk_100);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_timeout_evt", 32'(timeout_evt), 32'd0);
        a_rst_n = 1'b1;

        // Round-robin among four simultaneous single-word bursts
        base = log_owner.size();
        q[0].push_back({1'b1, 8'h40});
        q[0].push_back({1'b1, 8'h44});
        q[1].push_back({1'b1, 8'h41});
        q[2].push_back({1'b1, 8'h42});
        q[3].push_back({1'b1, 8'h43});
        drive_inputs();
        run_until_log(base + 5, 100, "rr_done");
        for (int i = 0; i < 5; i++)
            if (log_owner.size() > base + i)
                check($sformatf("rr_order%0d", i), 32'(log_owner[base + i]), 32'(exp_rr[i]));
        repeat (2) cycle();

        // Single request: latency, one data cycle, RELEASE, IDLE
        q[2].push_back({1'b1, 8'hA5});
        drive_inputs();
        cycle();
        check("s1_arb_lat_busy", 32'(s_busy), 32'd0);
        cycle();
        check("s1_grant", 32'(s_gid), 32'd2);
        check("s1_txv", 32'(s_txv), 32'd1);
        check("s1_data", 32'(s_data), 32'hA5);
        cycle();
        check("s1_release_busy", 32'(s_busy), 32'd1);
        check("s1_release_txv", 32'(s_txv), 32'd0);
        cycle();
        check("s1_idle_busy", 32'(s_busy), 32'd0);
        repeat (2) cycle();

        // Burst lock: req 0 waits for the whole req 1 burst
        base = log_owner.size();
        q[1].push_back({1'b0, 8'h11});
        q[1].push_back({1'b0, 8'h22});
        q[1].push_back({1'b1, 8'h33});
        drive_inputs();
        repeat (2) cycle();
        q[0].push_back({1'b1, 8'h55});
        drive_inputs();
        run_until_log(base + 4, 100, "s3_done");
        for (int i = 0; i < 4; i++)
            if (log_owner.size() > base + i) begin
                check($sformatf("s3_owner%0d", i), 32'(log_owner[base + i]), (i < 3) ? 32'd1 : 32'd0);
                check($sformatf("s3_data%0d", i), 32'(log_data[base + i]), 32'(exp_s3[i]));
            end
        repeat (2) cycle();

        // Backpressure: word held for 5 cycles with tx_ready low
        base = log_owner.size();
        tx_ready = 1'b0;
        q[2].push_back({1'b1, 8'h66});
        drive_inputs();
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("s4_hold_txv", 32'(s_txv), 32'd1);
            check("s4_hold_data", 32'(s_data), 32'h66);
            check("s4_hold_ready", 32'(s_rdy), 32'd0);
        end
        tx_ready = 1'b1;
        run_until_log(base + 1, 10, "s4_done");
        check("s4_ready_rise", 32'(s_rdy), 32'h4);
        repeat (2) cycle();

        // Timeout: owner 3 stalls mid-burst
        base = log_owner.size();
        q[3].push_back({1'b0, 8'h77});
        q[3].push_back({1'b1, 8'h78});
        drive_inputs();
        run_until_log(base + 1, 20, "s5_first");
        stall[3] = 1'b1;
        q[1].push_back({1'b1, 8'h81});
        q[2].push_back({1'b1, 8'h82});
        drive_inputs();
        k = 0;
        s_tevt = 1'b0;
        while (!s_tevt && k < 40) begin
            cycle();
            k++;
        end
        check("s5_timeout_cycles", 32'(k), 32'd17);
        run_until_log(base + 2, 20, "s5_next");
        if (log_owner.size() > base + 1)
            check("s5_next_owner", 32'(log_owner[base + 1]), 32'd1);
        stall[3] = 1'b0;
        drive_inputs();
        drain("s5_drain");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q[i].size() < 6 && $urandom_range(0, 7) == 0)
                    q[i].push_back({1'($urandom_range(0, 2) == 0), 8'($urandom)});
                if ($urandom_range(0, 63) == 0) stall[i] = !stall[i];
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            drive_inputs();
            cycle();
        end
        for (int i = 0; i < N; i++) stall[i] = 1'b0;
        tx_ready = 1'b1;
        drive_inputs();
        drain("rand_drain");

        // Reset in the middle of a burst
        base = log_owner.size();
        q[2].push_back({1'b0, 8'h91});
        q[2].push_back({1'b0, 8'h92});
        q[2].push_back({1'b1, 8'h93});
        drive_inputs();
        run_until_log(base + 1, 20, "s6_first");
        q[1].push_back({1'b1, 8'hA1});
        q[0].push_back({1'b1, 8'hA0});
        tx_ready = 1'b0;
        drive_inputs();
        cycle();
        #3;
        a_rst_n = 1'b0;
        #1;
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_txv", 32'(tx_valid), 32'd0);
        check("s6_rst_ready", 32'(req_ready), 32'd0);
        check("s6_rst_grant", 32'(grant_id), 32'd0);
        check("s6_rst_tevt", 32'(timeout_evt), 32'd0);
        model_reset();
        @(posedge clk_100);
        #1;
        a_rst_n = 1'b1;
        check("s6_no_word", 32'(log_owner.size()), 32'(base + 1));
        tx_ready = 1'b1;
        run_until_log(base + 2, 20, "s6_next");
        if (log_owner.size() > base + 1)
            check("s6_next_owner", 32'(log_owner[base + 1]), 32'd0);
        drain("s6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 The block SHALL have parameter P_NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 The block SHALL have parameter P_DATA_WIDTH, default 8: word width, equal to the transmitter data width.
REQ-003 The block SHALL have parameter P_LOCK_TIMEOUT, default 16: idle cycles before a locked burst is forcibly released, range 1..255.
REQ-004 Port clk_100, input, 1 bit: single clock, and all logic SHALL be rising-edge.
REQ-005 Port a_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port req_valid, input, P_NUM_REQ bits: per-requester word valid.
REQ-007 Port req_data, input, P_NUM_REQ x P_DATA_WIDTH bits: per-requester word.
REQ-008 Port req_last, input, P_NUM_REQ bits: marks the final word of a requester burst.
REQ-009 Port req_ready, output, P_NUM_REQ bits: per-requester word accepted when req_valid and req_ready are both high.
REQ-010 Port tx_valid, output, 1 bit: word valid to the transmitter.
REQ-011 Port tx_data, output, P_DATA_WIDTH bits: word to the transmitter.
REQ-012 Port tx_ready, input, 1 bit: transmitter ready.
REQ-013 Port grant_id, output, clog2(P_NUM_REQ) bits: index of the current owner.
REQ-014 Port busy, output, 1 bit: high while any requester owns the transmitter.
REQ-015 Port timeout_evt, output, 1 bit: one-cycle pulse when a lock is force-released.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-017 In IDLE with any req_valid high, the FSM SHALL register the winner into grant_id and enter GRANT on the next edge, giving 1 cycle of arbitration latency.
REQ-018 The winner SHALL be the first requester with req_valid high, searching upward from rr_ptr and wrapping from P_NUM_REQ-1 to 0.
REQ-019 In GRANT, tx_valid SHALL equal req_valid[grant_id] and tx_data SHALL equal req_data[grant_id], both combinationally.
REQ-020 In GRANT, req_ready[grant_id] SHALL equal tx_ready, and all other req_ready bits SHALL be 0.
REQ-021 In IDLE and RELEASE, all req_ready bits and tx_valid SHALL be 0.
REQ-022 Once tx_valid is high, it SHALL stay high, with tx_data stable, until the tx_valid/tx_ready handshake occurs, provided the owner holds its request.
REQ-023 A handshake with req_last[grant_id] high SHALL move the FSM to RELEASE and set rr_ptr to grant_id+1, wrapping to 0.
REQ-024 A handshake with req_last low SHALL keep the FSM in GRANT so the burst stays locked to the owner.
REQ-025 In GRANT, an idle counter SHALL increment on every cycle with req_valid[grant_id] low and SHALL clear on any cycle with it high.
REQ-026 When the idle counter reaches P_LOCK_TIMEOUT, the FSM SHALL pulse timeout_evt, advance rr_ptr as in REQ-023, and enter RELEASE.
REQ-027 RELEASE SHALL last exactly 1 cycle and then return to IDLE, so back-to-back owners are separated by at least 2 cycles with tx_valid low.
REQ-028 busy SHALL be high in GRANT and RELEASE, and low in IDLE.
REQ-029 If req_last and the timeout occur in the same cycle, the handshake SHALL take priority and timeout_evt SHALL stay 0.
REQ-030 Requests from non-owners SHALL be held pending and never dropped, and the arbiter SHALL never assert req_ready to them.

Reset
REQ-031 While a_rst_n is low: FSM SHALL be IDLE, rr_ptr 0, idle counter 0, grant_id 0, busy 0, timeout_evt 0, tx_valid 0, req_ready all 0.
REQ-032 Reset asserted mid-burst SHALL abandon the burst immediately, with no word completed after assertion.
REQ-033 After reset deasserts, the first arbitration SHALL start from index 0.

Structure
REQ-034 A shared package spi_pkg SHALL hold the FSM state enum (arb_state_t) and the default data width constant.
REQ-035 A single sub-module, rr_picker, SHALL be used: a combinational round-robin first-one search from rr_ptr that outputs a found flag and an index.
REQ-036 The FSM, rr_ptr, idle counter and output muxing SHALL reside in spi_tx_arbiter.

Verification
REQ-037 Scenario 1, single request: req 2 sends 8'hA5 with last=1 and tx_ready=1 -> grant_id=2 one cycle after valid, tx_data=A5 with tx_valid=1 for 1 cycle, then RELEASE, then IDLE.
REQ-038 Scenario 2, round-robin: all 4 requesters held valid with last=1 -> grant order 0,1,2,3,0.
REQ-039 Scenario 3, burst lock: req 1 sends 3 words 11,22,33 with last on 33 while req 0 stays valid -> req 0 is not granted until after word 33.
REQ-040 Scenario 4, backpressure: tx_ready low for 5 cycles during GRANT -> tx_valid and tx_data hold unchanged and req_ready stays 0 until tx_ready rises.
REQ-041 Scenario 5, timeout: owner 3 drops valid mid-burst -> timeout_evt pulses after 16 idle cycles, and the next grant goes to the lowest pending index found searching from 0.
REQ-042 Scenario 6, reset mid-burst: a_rst_n pulsed low in GRANT -> all outputs reach reset values asynchronously, and the next grant starts from index 0.
